// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : MEM-stage load/store engine. Issues word-bus transactions with
//               byte enables, positions store data and extends load results.
//               Optional macro MEM_SPLIT_MISALIGNED_EN splits misaligned
//               accesses into two bus transactions instead of faulting.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
  parameter int          ADDR_W          = 32,
  parameter logic [31:0] LANE_RESET_DATA = 32'h0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        inst_size,
  input  logic              is_signed,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              fault,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_ack
);

  localparam logic [1:0] c_IDLE      = 2'd0;
  localparam logic [1:0] c_BUS1      = 2'd1;
`ifdef MEM_SPLIT_MISALIGNED_EN
  localparam logic [1:0] c_BUS2      = 2'd2;
`endif
  localparam logic [1:0] c_RESP      = 2'd3;

  localparam logic [1:0] c_SIZE_BYTE = 2'd0;
  localparam logic [1:0] c_SIZE_HALF = 2'd1;
  localparam logic [1:0] c_SIZE_WORD = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [1:0]        r_off;
  logic              r_bus_req;
  logic              r_bus_we;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [3:0]        r_bus_be;
  logic [31:0]       r_bus_wdata;
  logic              r_done;
  logic              r_fault;
  logic [31:0]       r_rdata;
`ifdef MEM_SPLIT_MISALIGNED_EN
  logic              r_split;
  logic [3:0]        r_be_hi;
  logic [31:0]       r_first;
  logic [3:0]        w_be_hi;
  logic              w_advance;
  logic [63:0]       w_rd64;
`endif

  logic              w_accept;
  logic              w_launch;
  logic              w_fault_now;
  logic              w_complete;
  logic              w_misaligned;
  logic [1:0]        w_off;
  logic [1:0]        w_size;
  logic [3:0]        w_mask;
  logic [3:0]        w_be_lo;
  logic [31:0]       w_rep;
  logic [31:0]       w_wdata_rot;
  logic [31:0]       w_sh32;
  logic [31:0]       w_load;

  assign w_off    = addr[1:0];
  assign w_accept = (r_state == c_IDLE) && valid && (mem_read || mem_write);

  always_comb begin
    w_size = c_SIZE_WORD;
    w_mask = 4'b1111;
    w_rep  = wdata;
    if (inst_size == c_SIZE_BYTE) begin
      w_size = c_SIZE_BYTE;
      w_mask = 4'b0001;
      w_rep  = {4{wdata[7:0]}};
    end else if (inst_size == c_SIZE_HALF) begin
      w_size = c_SIZE_HALF;
      w_mask = 4'b0011;
      w_rep  = {2{wdata[15:0]}};
    end
  end

  assign w_misaligned = ((w_size == c_SIZE_HALF) && w_off[0]) ||
                        ((w_size == c_SIZE_WORD) && (w_off != 2'b00));
  assign w_be_lo      = 4'({4'b0000, w_mask} << w_off);
  // Rotating the replicated pattern puts each byte in its lane for both halves of a split
  assign w_wdata_rot  = 32'(({w_rep, w_rep} << {w_off, 3'b000}) >> 32);

`ifdef MEM_SPLIT_MISALIGNED_EN
  assign w_be_hi     = 4'(({4'b0000, w_mask} << w_off) >> 4);
  assign w_fault_now = 1'b0;
  assign w_advance   = bus_ack && (r_state == c_BUS1) && r_split;
  assign w_complete  = bus_ack && (((r_state == c_BUS1) && !r_split) || (r_state == c_BUS2));
  assign w_rd64      = (r_state == c_BUS2) ? {bus_rdata, r_first} : {32'h0, bus_rdata};
  assign w_sh32      = 32'(w_rd64 >> {r_off, 3'b000});
  assign stall       = (r_state == c_BUS1) || (r_state == c_BUS2) || w_accept;
`else
  assign w_fault_now = w_accept && w_misaligned;
  assign w_complete  = bus_ack && (r_state == c_BUS1);
  assign w_sh32      = bus_rdata >> {r_off, 3'b000};
  assign stall       = (r_state == c_BUS1) || w_accept;
`endif
  assign w_launch    = w_accept && !w_fault_now;

  always_comb begin
    w_load = w_sh32;
    if (r_size == c_SIZE_BYTE)
      w_load = {{24{r_signed & w_sh32[7]}}, w_sh32[7:0]};
    else if (r_size == c_SIZE_HALF)
      w_load = {{16{r_signed & w_sh32[15]}}, w_sh32[15:0]};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= c_IDLE;
      r_size      <= c_SIZE_WORD;
      r_signed    <= 1'b0;
      r_off       <= 2'b00;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_be    <= 4'b0000;
      r_bus_wdata <= 32'h0;
      r_done      <= 1'b0;
      r_fault     <= 1'b0;
      r_rdata     <= LANE_RESET_DATA;
`ifdef MEM_SPLIT_MISALIGNED_EN
      r_split     <= 1'b0;
      r_be_hi     <= 4'b0000;
      r_first     <= 32'h0;
`endif
    end else begin
      r_done  <= 1'b0;
      r_fault <= 1'b0;
      r_rdata <= LANE_RESET_DATA;
      if (w_accept) begin
        r_size   <= w_size;
        r_signed <= is_signed;
        r_off    <= w_off;
`ifdef MEM_SPLIT_MISALIGNED_EN
        r_split  <= w_misaligned;
        r_be_hi  <= w_be_hi;
`endif
      end
      if (w_launch) begin
        r_bus_req   <= 1'b1;
        r_bus_we    <= mem_write && !mem_read;
        r_bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
        r_bus_be    <= w_be_lo;
        r_bus_wdata <= w_wdata_rot;
        r_state     <= c_BUS1;
      end
      if (w_fault_now) begin
        r_done  <= 1'b1;
        r_fault <= 1'b1;
        r_state <= c_RESP;
      end
`ifdef MEM_SPLIT_MISALIGNED_EN
      if (w_advance) begin
        r_first    <= bus_rdata;
        r_bus_addr <= r_bus_addr + ADDR_W'(4);
        r_bus_be   <= r_be_hi;
        r_state    <= c_BUS2;
      end
`endif
      if (w_complete) begin
        r_bus_req   <= 1'b0;
        r_bus_we    <= 1'b0;
        r_bus_addr  <= '0;
        r_bus_be    <= 4'b0000;
        r_bus_wdata <= 32'h0;
        r_done      <= 1'b1;
        r_rdata     <= r_bus_we ? LANE_RESET_DATA : w_load;
        r_state     <= c_RESP;
      end
      if (r_state == c_RESP)
        r_state <= c_IDLE;
    end
  end

  assign done      = r_done;
  assign fault     = r_fault;
  assign rdata     = r_rdata;
  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_be    = r_bus_be;
  assign bus_wdata = r_bus_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Directed bench for mem_access_unit with a byte-level model of
//               loads, stores and bus splitting (MEM_SPLIT_MISALIGNED_EN aware).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

`ifdef MEM_SPLIT_MISALIGNED_EN
  localparam bit c_SPLIT = 1'b1;
`else
  localparam bit c_SPLIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        valid = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [1:0]  inst_size = 2'd0;
  logic        is_signed = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        stall;
  logic        done;
  logic [31:0] rdata;
  logic        fault;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata = 32'h0;
  logic        bus_ack = 1'b0;

  int checks = 0;
  int errors = 0;

  mem_access_unit #(.ADDR_W(32), .LANE_RESET_DATA(32'h0)) dut (
    .clk(clk), .reset(reset), .valid(valid), .mem_read(mem_read),
    .mem_write(mem_write), .inst_size(inst_size), .is_signed(is_signed),
    .addr(addr), .wdata(wdata), .stall(stall), .done(done), .rdata(rdata),
    .fault(fault), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One load/store, with the unit acting as bus slave that acks after w wait cycles.
  task automatic access(input logic rd, input logic wr, input logic [1:0] sz,
                        input logic sgn, input logic [31:0] a, input logic [31:0] wd,
                        input int w, input logic [31:0] rd0, input logic [31:0] rd1,
                        input logic [31:0] lit);
    int nb, ntx, t, lane, stall_cnt;
    logic mis, flt, is_store;
    logic [3:0]  ebe [0:1];
    logic [31:0] ewd [0:1];
    logic [31:0] res, ba, src, lm;
    nb       = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    mis      = (a % nb) != 0;
    flt      = mis && !c_SPLIT;
    ntx      = flt ? 0 : (mis ? 2 : 1);
    is_store = wr && !rd;
    ebe[0] = 4'h0; ebe[1] = 4'h0; ewd[0] = 32'h0; ewd[1] = 32'h0; res = 32'h0;
    for (int i = 0; i < nb; i++) begin
      ba   = a + 32'(i);
      t    = (ba[31:2] != a[31:2]) ? 1 : 0;
      lane = int'(ba[1:0]);
      ebe[t][lane] = 1'b1;
      ewd[t][8*lane +: 8] = wd[8*i +: 8];
      src = (t == 0) ? rd0 : rd1;
      res[8*i +: 8] = src[8*lane +: 8];
    end
    for (int i = nb; i < 4; i++)
      res[8*i +: 8] = (sgn && res[8*nb-1]) ? 8'hFF : 8'h00;
    if (is_store || flt) res = 32'h0;
    lm = 32'hFFFF_FFFF;
    if (!mis && nb == 1) ewd[0] = {4{wd[7:0]}};
    else if (!mis && nb == 2) ewd[0] = {2{wd[15:0]}};
    else if (mis) lm = 32'h0;

    @(negedge clk);
    valid = 1'b1; mem_read = rd; mem_write = wr; inst_size = sz;
    is_signed = sgn; addr = a; wdata = wd;
    #1;
    stall_cnt = 0;
    if (stall) stall_cnt++;
    chk("accept_stall", {31'h0, stall}, 32'h1);
    chk("accept_done", {31'h0, done}, 32'h0);
    @(negedge clk);
    valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    for (int tx = 0; tx < ntx; tx++) begin
      if (mis) lm = {{8{ebe[tx][3]}}, {8{ebe[tx][2]}}, {8{ebe[tx][1]}}, {8{ebe[tx][0]}}};
      for (int c = 0; c <= w; c++) begin
        if (c == w) begin
          bus_ack = 1'b1;
          bus_rdata = (tx == 0) ? rd0 : rd1;
        end
        #1;
        if (stall) stall_cnt++;
        chk("bus_req", {31'h0, bus_req}, 32'h1);
        chk("bus_addr", bus_addr, (a & ~32'h3) + 32'(4 * tx));
        chk("bus_be", {28'h0, bus_be}, {28'h0, ebe[tx]});
        chk("bus_we", {31'h0, bus_we}, {31'h0, is_store});
        if (is_store) chk("bus_wdata", bus_wdata & lm, ewd[tx] & lm);
        chk("bus_done", {31'h0, done}, 32'h0);
        @(negedge clk);
        bus_ack = 1'b0;
        bus_rdata = 32'h0BAD_0BAD;
      end
    end
    #1;
    chk("resp_done", {31'h0, done}, 32'h1);
    chk("resp_fault", {31'h0, fault}, {31'h0, flt});
    chk("resp_rdata", rdata, res);
    chk("resp_rdata_lit", rdata, lit);
    chk("resp_stall", {31'h0, stall}, 32'h0);
    chk("resp_bus_req", {31'h0, bus_req}, 32'h0);
    chk("stall_cycles", 32'(stall_cnt), 32'(1 + ntx * (w + 1)));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_fault", {31'h0, fault}, 32'h0);
    chk("rst_bus_req", {31'h0, bus_req}, 32'h0);
    chk("rst_bus_we", {31'h0, bus_we}, 32'h0);
    chk("rst_bus_be", {28'h0, bus_be}, 32'h0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_bus_wdata", bus_wdata, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    reset = 1'b1;

    // No live memory op: unit stays idle
    @(negedge clk);
    valid = 1'b0; mem_read = 1'b1;
    #1 chk("idle_novalid_stall", {31'h0, stall}, 32'h0);
    @(negedge clk);
    valid = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
    #1 chk("idle_noop_stall", {31'h0, stall}, 32'h0);
    chk("idle_bus_req", {31'h0, bus_req}, 32'h0);
    @(negedge clk);
    valid = 1'b0;
    #1 chk("idle_bus_req2", {31'h0, bus_req}, 32'h0);

    //     rd    wr    size  sgn   addr          wdata         w  rd0           rd1           literal
    access(1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_0104, 32'hDEAD_BEEF, 1, 32'h0,        32'h0,        32'h0);
    access(1'b1, 1'b0, 2'd0, 1'b1, 32'h0000_0203, 32'h0,        0, 32'h80FF_FFFF, 32'h0,        32'hFFFF_FF80);
    access(1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_0203, 32'h0,        0, 32'h80FF_FFFF, 32'h0,        32'h0000_0080);
    access(1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_0302, 32'h0000_ABCD, 2, 32'h0,        32'h0,        32'h0);
    access(1'b1, 1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'h5555_5555, 0, 32'h1234_5678, 32'h0,       32'h1234_5678);
    access(1'b1, 1'b0, 2'd1, 1'b1, 32'h0000_0106, 32'h0,        1, 32'h8001_0000, 32'h0,        32'hFFFF_8001);
    access(1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_0000, 32'h0,        0, 32'h1234_F00D, 32'h0,        32'h0000_F00D);
    access(1'b1, 1'b0, 2'd3, 1'b1, 32'h0000_0020, 32'h0,        0, 32'hCAFE_F00D, 32'h0,        32'hCAFE_F00D);
    access(1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_0031, 32'h0000_005A, 0, 32'h0,        32'h0,        32'h0);
`ifdef MEM_SPLIT_MISALIGNED_EN
    access(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0401, 32'h0,        0, 32'h3322_11AA, 32'hBBCC_DD44, 32'h4433_2211);
    access(1'b1, 1'b0, 2'd1, 1'b1, 32'h0000_0403, 32'h0,        1, 32'hA500_0000, 32'h0000_00FF, 32'hFFFF_FFA5);
`else
    access(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0401, 32'h0,        0, 32'h3322_11AA, 32'hBBCC_DD44, 32'h0);
    access(1'b1, 1'b0, 2'd1, 1'b1, 32'h0000_0403, 32'h0,        1, 32'hA500_0000, 32'h0000_00FF, 32'h0);
`endif
    access(1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_0102, 32'h1122_3344, 0, 32'h0,        32'h0,        32'h0);

    // Reset while a bus transaction is outstanding, then a stray ack
    @(negedge clk);
    valid = 1'b1; mem_read = 1'b1; inst_size = 2'd2; addr = 32'h0000_0010;
    @(negedge clk);
    valid = 1'b0; mem_read = 1'b0;
    #1 chk("pre_rst_bus_req", {31'h0, bus_req}, 32'h1);
    reset = 1'b0;
    @(negedge clk);
    #1 chk("mid_rst_bus_req", {31'h0, bus_req}, 32'h0);
    chk("mid_rst_stall", {31'h0, stall}, 32'h0);
    chk("mid_rst_bus_be", {28'h0, bus_be}, 32'h0);
    reset = 1'b1;
    bus_ack = 1'b1;
    bus_rdata = 32'hFEED_FACE;
    @(negedge clk);
    bus_ack = 1'b0;
    #1 chk("late_ack_done", {31'h0, done}, 32'h0);
    @(negedge clk);
    #1 chk("late_ack_done2", {31'h0, done}, 32'h0);
    chk("late_ack_rdata", rdata, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
MEM-stage load/store engine that executes the memory controls produced by instruction decode: mem_read, mem_write, inst_size and is_signed. It turns one load or store into 32-bit word-bus transactions with byte enables. For stores it replicates write data across byte lanes. For loads it extracts the addressed lane and sign/zero-extends the result. It holds the pipeline through a stall output while a bus transaction is outstanding.

Parameters:
ADDR_W, 32, byte address width.
LANE_RESET_DATA, 32'h0, value driven on rdata when no load result is valid.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-low reset.
valid  in  1  EX/MEM register holds a live instruction.
mem_read  in  1  load request from decode.
mem_write  in  1  store request from decode.
inst_size  in  2  `BYTE / `HALF / `WORD; any other code is treated as `WORD.
is_signed  in  1  1 = sign-extend the load result, 0 = zero-extend.
addr  in  ADDR_W  byte address (ALU result).
wdata  in  32  store data (rs2).
stall  out  1  hold the upstream pipeline.
done  out  1  one-cycle pulse: access complete.
rdata  out  32  extended load result, valid while done=1.
fault  out  1  misaligned access, valid while done=1.
bus_req  out  1  bus request.
bus_we  out  1  1 = write.
bus_addr  out  ADDR_W  word-aligned address, addr[1:0] forced to 2'b00.
bus_be  out  4  byte enables.
bus_wdata  out  32  lane-positioned write data.
bus_rdata  in  32  read data, valid when bus_ack=1.
bus_ack  in  1  transaction complete, sampled on clk.

Behaviour:
- Reset (reset=0 at a clk edge) returns state to IDLE and clears all registered outputs: stall=0, done=0, fault=0, bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, rdata=LANE_RESET_DATA.
- Reset mid-transaction: bus_req drops at that same edge, and any late bus_ack is ignored.
- FSM states: IDLE, BUS1, BUS2 (only when the optional feature is compiled in), RESP.
- Accept condition: valid && (mem_read || mem_write) while in IDLE.
  - The request is latched on that edge and the state moves to BUS1.
  - If mem_read and mem_write are both 1, the access is treated as a read.
- stall is combinational: (state==BUS1 || state==BUS2) || (state==IDLE && accept). stall=0 in RESP.
- BUS1: bus_req=1. addr, be, we and wdata stay stable until bus_ack=1 is sampled.
  - On bus_ack, go to RESP, or to BUS2 if the access is split.
  - Back-to-back ack is legal, so the minimum latency is 1 bus cycle.
- Byte enables, with off=addr[1:0]:
  - `BYTE: bus_be = 1<<off.
  - `HALF: bus_be = 4'b0011<<off.
  - `WORD: bus_be = 4'b1111.
- Store data: bus_wdata = wdata shifted left by 8*off. For `BYTE and `HALF the unused lanes carry the replicated byte/half.
- Load result: the word is shifted right by 8*off, masked to 8, 16 or 32 bits, then extended according to is_signed. For `WORD, is_signed has no effect.
- RESP: lasts one cycle with done=1; the load result is driven on rdata. Next state is IDLE. For stores rdata=LANE_RESET_DATA.
- New requests are accepted only in IDLE; RESP never accepts, so there is one idle cycle between accesses.
- Misaligned access: `HALF with off[0]=1, or `WORD with off!=0. With the feature off:
  - No bus cycle is issued; the state goes IDLE→RESP directly.
  - In RESP: fault=1, rdata=LANE_RESET_DATA, stall=1 during the accept cycle only.
- valid=0 or no memory op: the unit stays in IDLE, stall=0, and bus outputs hold their reset values.

Optional Feature:
Macro MEM_SPLIT_MISALIGNED_EN.
- Defined: misaligned accesses never fault. They are split into two transactions:
  - BUS1 uses the word at addr & ~3 with bus_be = (size mask<<off)[3:0].
  - BUS2 uses word+4 with bus_be = (size mask<<off)[7:4].
  - Loads concatenate {second,first} before shifting.
  - fault stays 0.
- Undefined: BUS2 is absent and misaligned accesses fault as described in Behaviour.

Test Plan:
- SW addr=0x104, wdata=0xDEADBEEF, ack after 2 cycles → bus_addr=0x104, be=1111, we=1, stall high 3 cycles, done pulses once, fault=0.
- LB addr=0x203, signed, bus_rdata=0x80FFFFFF → be=1000, rdata=0xFFFFFF80. Same access as LBU → rdata=0x00000080.
- SH addr=0x302, wdata=0x0000ABCD → be=1100, bus_wdata[31:16]=0xABCD.
- LW addr=0x401 → without the macro: no bus_req, done=1, fault=1, rdata=0. With the macro: two transactions at 0x400 (be=1110) and 0x404 (be=0001); rdatas 0x332211xx and 0xxxxxxx44 → rdata=0x44332211.
- reset=0 asserted while in BUS1 with bus_ack held low → bus_req=0 and state IDLE after the edge; an ack one cycle later produces no done.
- mem_read=mem_write=1, addr=0x10, bus_rdata=0x12345678 → we=0, read performed, rdata=0x12345678.
